// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// Opcodes, funct codes, ALU op codes, FSM states and the output bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [2:0] ALU_OP_ADD  = 3'b000;
  localparam logic [2:0] ALU_OP_SUB  = 3'b001;
  localparam logic [2:0] ALU_OP_OR   = 3'b010;
  localparam logic [2:0] ALU_OP_AND  = 3'b011;
  localparam logic [2:0] ALU_OP_NOR  = 3'b101;
  localparam logic [2:0] ALU_OP_NOT  = 3'b110;
  localparam logic [2:0] ALU_OP_HOLD = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_MEM_WB,
    S_BRANCH, S_JUMP, S_ILLEGAL, S_TRAP
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_OP_HOLD;
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Memory request/acknowledge bus between the control unit and memory.
interface mips_mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ack;

  modport master (
    output mem_req, mem_we, i_or_d,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_we, i_or_d,
    output mem_ack
  );
endinterface

// File: rtl/mips_alu_dec.sv
// Combinational (opcode, funct) -> ALU operation decoder.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_OP_HOLD;
    valid  = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        valid = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_OP_ADD;
          FN_SUB:  alu_op = ALU_OP_SUB;
          FN_AND:  alu_op = ALU_OP_AND;
          FN_OR:   alu_op = ALU_OP_OR;
          FN_NOR:  alu_op = ALU_OP_NOR;
          default: valid  = 1'b0;
        endcase
      end
      op == OP_ADDI: begin
        alu_op = ALU_OP_ADD;
        valid  = 1'b1;
      end
      op == OP_ANDI: begin
        alu_op = ALU_OP_AND;
        valid  = 1'b1;
      end
      op == OP_ORI: begin
        alu_op = ALU_OP_OR;
        valid  = 1'b1;
      end
      (op == OP_LW) || (op == OP_SW): begin
        alu_op = ALU_OP_ADD;
        valid  = 1'b1;
      end
      op == OP_BEQ: begin
        alu_op = ALU_OP_SUB;
        valid  = 1'b1;
      end
      op == OP_J: valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with registered datapath controls.
// Define CTRL_TRAP_EN to trap on illegal instructions instead of NOP.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] instr_op,
  input  logic [5:0] instr_funct,
  input  logic       alu_zero,
  mips_mc_ctrl_if.master mem,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       mem_err
`ifdef CTRL_TRAP_EN
  ,
  output logic       trap
`endif
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e        state_q, state_d;
  ctrl_t         ctl_q, ctl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [2:0]    dec_op;
  logic          dec_ok;
  logic          in_mem;
  logic          ack;
  logic          tmo;

  mips_alu_dec u_dec (
    .op     (instr_op),
    .funct  (instr_funct),
    .alu_op (dec_op),
    .valid  (dec_ok)
  );

  assign ack    = mem.mem_ack;
  assign in_mem = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                  (state_q == S_MEM_WR);
  // An ack in the final waiting cycle takes priority over the timeout.
  assign tmo = (MEM_TIMEOUT != 0) && in_mem && !ack &&
               (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (ack)      state_d = S_DECODE;
        else if (tmo) state_d = S_IDLE;
      end
      S_DECODE: begin
        unique case (1'b1)
          instr_op == OP_RTYPE:
            state_d = dec_ok ? S_EXEC_R : S_ILLEGAL;
          (instr_op == OP_LW) || (instr_op == OP_SW):
            state_d = S_MEM_ADDR;
          instr_op == OP_BEQ: state_d = S_BRANCH;
          instr_op == OP_J:   state_d = S_JUMP;
          (instr_op == OP_ADDI) || (instr_op == OP_ANDI) ||
          (instr_op == OP_ORI):
            state_d = S_EXEC_I;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR:
        state_d = (instr_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (ack)      state_d = S_MEM_WB;
        else if (tmo) state_d = S_IDLE;
      end
      S_MEM_WR: begin
        if (ack)      state_d = S_FETCH;
        else if (tmo) state_d = S_IDLE;
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
`ifdef CTRL_TRAP_EN
      S_ILLEGAL:  state_d = S_TRAP;
      S_TRAP:     state_d = S_TRAP;
`else
      S_ILLEGAL:  state_d = S_FETCH;
      S_TRAP:     state_d = S_FETCH;
`endif
      default:    state_d = S_IDLE;
    endcase
  end

  // Controls are decoded from the next state so they are flop outputs.
  always_comb begin
    ctl_d = ctrl_idle();
    unique case (state_d)
      S_FETCH: begin
        ctl_d.mem_req   = 1'b1;
        ctl_d.alu_src_b = 2'b01;
        ctl_d.alu_op    = ALU_OP_ADD;
      end
      S_DECODE: begin
        ctl_d.alu_src_b = 2'b11;
        ctl_d.alu_op    = ALU_OP_ADD;
      end
      S_EXEC_R: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_op    = dec_op;
      end
      S_EXEC_I: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_src_b = 2'b10;
        ctl_d.alu_op    = dec_op;
      end
      S_WB_R: begin
        ctl_d.reg_write = 1'b1;
        ctl_d.reg_dst   = 1'b1;
      end
      S_WB_I: ctl_d.reg_write = 1'b1;
      S_MEM_ADDR: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_src_b = 2'b10;
        ctl_d.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctl_d.mem_req = 1'b1;
        ctl_d.i_or_d  = 1'b1;
      end
      S_MEM_WR: begin
        ctl_d.mem_req = 1'b1;
        ctl_d.i_or_d  = 1'b1;
        ctl_d.mem_we  = 1'b1;
      end
      S_MEM_WB: begin
        ctl_d.mem_to_reg = 1'b1;
        ctl_d.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctl_d.alu_src_a = 1'b1;
        ctl_d.alu_op    = ALU_OP_SUB;
        ctl_d.pc_src    = 2'b01;
      end
      S_JUMP: begin
        ctl_d.pc_src = 2'b10;
        ctl_d.pc_wr  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
  assign err_d = err_q | tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctl_q   <= ctrl_idle();
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef CTRL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= (state_d == S_TRAP);
  end
  assign trap = trap_q;
`endif

  // Fetch and branch strobes are qualified by the ack / zero of this cycle.
  assign ir_write = (state_q == S_FETCH) && ack;
  assign pc_write = ctl_q.pc_wr || ir_write ||
                    ((state_q == S_BRANCH) && alu_zero);

  assign mem.mem_req = ctl_q.mem_req;
  assign mem.mem_we  = ctl_q.mem_we;
  assign mem.i_or_d  = ctl_q.i_or_d;
  assign pc_src      = ctl_q.pc_src;
  assign reg_write   = ctl_q.reg_write;
  assign reg_dst     = ctl_q.reg_dst;
  assign mem_to_reg  = ctl_q.mem_to_reg;
  assign alu_src_a   = ctl_q.alu_src_a;
  assign alu_src_b   = ctl_q.alu_src_b;
  assign alu_op      = ctl_q.alu_op;
  assign mem_err     = err_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-cycle expected outputs from an
// instruction-level model are queued and checked by an independent monitor.
module tb_mips_mc_ctrl;

  localparam int TO = 4;

  typedef struct packed {
    logic       req, we, iod, irw, pcw;
    logic [1:0] pcs;
    logic       rw, rd, m2r, sa;
    logic [1:0] sb;
    logic [2:0] op;
    logic       err, tr;
  } ov_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] instr_op, instr_funct;
  logic alu_zero;
  logic ir_write, pc_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic mem_err;
  logic trap_w;

  mips_mc_ctrl_if mif ();

  mips_mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_op    (instr_op),
    .instr_funct (instr_funct),
    .alu_zero    (alu_zero),
    .mem         (mif.master),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .mem_err     (mem_err)
`ifdef CTRL_TRAP_EN
    ,
    .trap        (trap_w)
`endif
  );

`ifndef CTRL_TRAP_EN
  assign trap_w = 1'b0;
`endif

  always #5 clk = ~clk;

  ov_t expq[$];
  int  total = 0;
  int  bad = 0;
  int  ncyc = 0;
  bit  err_m = 1'b0;
  bit  trap_m = 1'b0;

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ov_t base();
    ov_t v;
    v = '0;
    v.op  = 3'b111;
    v.err = err_m;
    v.tr  = trap_m;
    return v;
  endfunction

  // {valid, alu_op} for the ALU-using instructions, straight from the ISA table.
  function automatic logic [3:0] alu_of(input logic [5:0] op,
                                        input logic [5:0] fn);
    if (op == 6'h08) return 4'b1000;
    if (op == 6'h0C) return 4'b1011;
    if (op == 6'h0D) return 4'b1010;
    case (fn)
      6'h20:   return 4'b1000;
      6'h22:   return 4'b1001;
      6'h24:   return 4'b1011;
      6'h25:   return 4'b1010;
      6'h27:   return 4'b1101;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic cyc(input ov_t v, input bit ack, input bit zero);
    @(posedge clk);
    #1;
    mif.mem_ack = ack;
    alu_zero    = zero;
    expq.push_back(v);
  endtask

  task automatic fetch(input int waits);
    ov_t v;
    v = base(); v.req = 1; v.sb = 2'b01; v.op = 3'b000;
    for (int i = 0; i < waits; i++) cyc(v, 1'b0, rnd());
    v.irw = 1; v.pcw = 1;
    cyc(v, 1'b1, rnd());
  endtask

  task automatic illegal();
    ov_t v;
    v = base();
    cyc(v, rnd(), rnd());
`ifdef CTRL_TRAP_EN
    trap_m = 1'b1;
    for (int i = 0; i < 6; i++) cyc(base(), rnd(), rnd());
`endif
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input bit zero, input int fw, input int mw);
    ov_t v;
    logic [3:0] a;
    instr_op    = op;
    instr_funct = fn;
    a = alu_of(op, fn);
    fetch(fw);
    v = base(); v.sb = 2'b11; v.op = 3'b000;
    cyc(v, rnd(), rnd());
    case (op)
      6'h00, 6'h08, 6'h0C, 6'h0D: begin
        if (!a[3]) illegal();
        else begin
          v = base(); v.sa = 1; v.op = a[2:0];
          v.sb = (op == 6'h00) ? 2'b00 : 2'b10;
          cyc(v, rnd(), rnd());
          v = base(); v.rw = 1; v.rd = (op == 6'h00);
          cyc(v, rnd(), rnd());
        end
      end
      6'h23, 6'h2B: begin
        v = base(); v.sa = 1; v.sb = 2'b10; v.op = 3'b000;
        cyc(v, rnd(), rnd());
        v = base(); v.req = 1; v.iod = 1; v.we = (op == 6'h2B);
        for (int i = 0; i < mw; i++) cyc(v, 1'b0, rnd());
        cyc(v, 1'b1, rnd());
        if (op == 6'h23) begin
          v = base(); v.m2r = 1; v.rw = 1;
          cyc(v, rnd(), rnd());
        end
      end
      6'h04: begin
        v = base(); v.sa = 1; v.op = 3'b001; v.pcs = 2'b01; v.pcw = zero;
        cyc(v, rnd(), zero);
      end
      6'h02: begin
        v = base(); v.pcs = 2'b10; v.pcw = 1;
        cyc(v, rnd(), rnd());
      end
      default: illegal();
    endcase
  endtask

  task automatic tmo_test(input bit ack4);
    ov_t v;
    if (ack4) begin
      run(6'h02, 6'h00, 1'b0, TO - 1, 0);
    end else begin
      instr_op = 6'h02;
      v = base(); v.req = 1; v.sb = 2'b01; v.op = 3'b000;
      for (int i = 0; i < TO; i++) cyc(v, 1'b0, rnd());
      err_m = 1'b1;
      cyc(base(), rnd(), rnd());
    end
  endtask

  // Monitor: every cycle the DUT presents a control word; check queue head.
  always @(negedge clk) begin
    ov_t act, e;
    ncyc++;
    act = {mif.mem_req, mif.mem_we, mif.i_or_d, ir_write, pc_write, pc_src,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           mem_err, trap_w};
    if (expq.size() != 0) begin
      e = expq.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL ctrl_word cycle=%0d got=%b want=%b", ncyc, act, e);
      end
    end
  end

  logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h08, 6'h0C,
                          6'h0D, 6'h23, 6'h2B, 6'h3F};
  logic [5:0] fns[7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h3F};

  initial begin
    logic [5:0] op, fn;
    rst_n = 1'b1;
    instr_op = '0;
    instr_funct = '0;
    alu_zero = 1'b0;
    mif.mem_ack = 1'b0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc(base(), rnd(), rnd());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mif.mem_ack = 1'b0;
    expq.push_back(base());

    tmo_test(1'b1);
    run(6'h00, 6'h20, 1'b0, 0, 0);
    run(6'h23, 6'h00, 1'b0, 0, 2);
    run(6'h04, 6'h00, 1'b1, 0, 0);
    run(6'h04, 6'h00, 1'b0, 1, 0);
    run(6'h2B, 6'h00, 1'b0, 0, 1);
    run(6'h08, 6'h11, 1'b0, 0, 0);
    run(6'h0C, 6'h11, 1'b0, 2, 0);
    run(6'h0D, 6'h11, 1'b0, 0, 0);
    run(6'h00, 6'h22, 1'b0, 0, 0);
    run(6'h00, 6'h24, 1'b0, 0, 0);
    run(6'h00, 6'h25, 1'b0, 0, 0);
    run(6'h00, 6'h27, 1'b0, 0, 0);
`ifndef CTRL_TRAP_EN
    run(6'h00, 6'h2A, 1'b0, 0, 0);
    run(6'h3F, 6'h00, 1'b0, 0, 0);
`endif

    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 9)];
      fn = fns[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
`ifdef CTRL_TRAP_EN
      if (!((op == 6'h00 && alu_of(op, fn) != 4'b0111) || op == 6'h02 ||
            op == 6'h04 || op == 6'h08 || op == 6'h0C || op == 6'h0D ||
            op == 6'h23 || op == 6'h2B)) begin
        op = 6'h00;
        fn = 6'h20;
      end
`endif
      run(op, fn, rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    tmo_test(1'b0);
    run(6'h00, 6'h20, 1'b0, 0, 0);
    run(6'h2B, 6'h00, 1'b0, 0, 0);
`ifdef CTRL_TRAP_EN
    run(6'h3F, 6'h00, 1'b0, 0, 0);
`endif

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
